cpu_trace_monitor: RTL and testbench

Synthesizable, parametrised run monitor attached beside the multicycle CPU, watching its `pc_out` and `ALU_OUT` buses. It detects instruction retirement (PC change), logs retired {PC, ALU result} pairs into an on-chip trace FIFO, and keeps cycle and instruction counters. It also flags a CPU halt (PC stuck) and a PC breakpoint. It replaces ad-hoc waveform inspection of CPU runs with a readable, self-describing trace port usable in both simulation and hardware.

---
 rtl/cpu_trace_pkg.sv | 21 ++
 rtl/cpu_trace_monitor_trace_fifo.sv | 70 +++++++
 rtl/cpu_trace_monitor.sv | 150 +++++++++++++++
 tb/tb_cpu_trace_monitor.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_trace_pkg.sv
// Shared types for the CPU trace monitor: FSM state codes and the trace entry.
package cpu_trace_pkg;

  // Monitor FSM; the numeric codes are visible on the state output.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_FROZEN = 2'd3
  } mon_state_t;

  // Default bus width of the attached CPU.
  localparam int DEFAULT_DATA_W = 32;

  // One retired instruction as stored in the trace FIFO: {pc, alu}.
  typedef struct packed {
    logic [DEFAULT_DATA_W-1:0] pc;
    logic [DEFAULT_DATA_W-1:0] alu;
  } trace_entry_t;

endpackage

// File: rtl/cpu_trace_monitor_trace_fifo.sv
// Show-ahead trace FIFO holding {pc, alu} pairs, with a selectable
// full policy (drop newest or drop oldest) and a sticky loss flag.
module trace_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DATA_W-1:0]       push_pc,
  input  logic [DATA_W-1:0]       push_alu,
  input  logic                    pop,
  input  logic                    overwrite,
  output logic [DATA_W-1:0]       head_pc,
  output logic [DATA_W-1:0]       head_alu,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [2*DATA_W-1:0] mem [DEPTH];
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic [2*DATA_W-1:0] head;
  logic                do_pop;
  logic                do_write;
  logic                adv_rd;
  logic                lost;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  // Head is forced to zero while empty so stale storage never shows.
  assign head     = mem[rd_ptr[AW-1:0]];
  assign head_pc  = empty ? '0 : head[2*DATA_W-1:DATA_W];
  assign head_alu = empty ? '0 : head[DATA_W-1:0];

  // A push into a full FIFO with no pop loses an entry; with overwrite the
  // oldest is evicted by advancing the read pointer over the write slot.
  always_comb begin
    do_pop   = pop && !empty;
    lost     = push && full && !do_pop;
    do_write = push && (!full || do_pop || overwrite);
    adv_rd   = do_pop || (lost && overwrite);
  end

  // Storage is not reset; clearing the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr[AW-1:0]] <= {push_pc, push_alu};
  end

  // Pointer and sticky overflow update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (adv_rd)   rd_ptr <= rd_ptr + (AW+1)'(1);
      if (lost)     overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/cpu_trace_monitor.sv
// Run monitor beside the multicycle CPU: detects retirement as a PC change,
// logs {old pc, alu} into a trace FIFO, counts cycles and instructions,
// and flags halts (PC stuck) and PC breakpoints.
module cpu_trace_monitor
  import cpu_trace_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int HALT_CYCLES = 8,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   overwrite,
  input  logic [DATA_W-1:0]      pc_in,
  input  logic [DATA_W-1:0]      alu_in,
  input  logic                   bp_en,
  input  logic [DATA_W-1:0]      bp_addr,
  input  logic                   resume,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_pc,
  output logic [DATA_W-1:0]      rd_alu,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [CNT_W-1:0]       cycle_cnt,
  output logic [CNT_W-1:0]       instr_cnt,
  output logic                   halted,
  output logic                   bp_hit,
  output logic [1:0]             state
);

  localparam int                 STALL_W    = $clog2(HALT_CYCLES);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(HALT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

  mon_state_t          state_q, state_d;
  logic [DATA_W-1:0]   pc_q, pc_d;
  logic [STALL_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]    cyc_q, cyc_d;
  logic [CNT_W-1:0]    ins_q, ins_d;
  logic                bp_hit_q, bp_hit_d;
  logic                retire;
  logic                push;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign retire    = (pc_in != pc_q);
  assign state     = state_q;
  assign halted    = (state_q == ST_HALTED);
  assign bp_hit    = bp_hit_q;
  assign cycle_cnt = cyc_q;
  assign instr_cnt = ins_q;

  // Next-state, counter and push decode. pc_q follows pc_in in every state
  // so pausing (en low, FROZEN, IDLE) never produces a spurious retire later.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_in;
    stall_d  = stall_q;
    cyc_d    = cyc_q;
    ins_d    = ins_q;
    bp_hit_d = 1'b0;
    push     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall_d = '0;
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (en) begin
          cyc_d = sat_inc(cyc_q);
          if (retire) begin
            push    = 1'b1;
            ins_d   = sat_inc(ins_q);
            stall_d = '0;
            if (bp_en && (pc_in == bp_addr)) begin
              state_d  = ST_FROZEN;
              bp_hit_d = 1'b1;
            end
          end else if (stall_q == STALL_LAST) begin
            state_d = ST_HALTED;
            stall_d = '0;
          end else begin
            stall_d = stall_q + STALL_W'(1);
          end
        end
      end
      ST_HALTED: begin
        if (en) begin
          cyc_d = sat_inc(cyc_q);
          if (retire) begin
            push    = 1'b1;
            ins_d   = sat_inc(ins_q);
            stall_d = '0;
            state_d = ST_RUN;
          end
        end
      end
      ST_FROZEN: begin
        stall_d = '0;
        if (resume) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Monitor state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      stall_q  <= '0;
      cyc_q    <= '0;
      ins_q    <= '0;
      bp_hit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      stall_q  <= stall_d;
      cyc_q    <= cyc_d;
      ins_q    <= ins_d;
      bp_hit_q <= bp_hit_d;
    end
  end

  trace_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_pc   (pc_q),
    .push_alu  (alu_in),
    .pop       (rd_en),
    .overwrite (overwrite),
    .head_pc   (rd_pc),
    .head_alu  (rd_alu),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Bench for cpu_trace_monitor: directed scenarios with literal expectations
// plus a randomized run, all compared every cycle against a behavioural model.
module tb_cpu_trace_monitor;
  import cpu_trace_pkg::*;

  localparam int DATA_W      = 32;
  localparam int DEPTH       = 4;
  localparam int HALT_CYCLES = 8;
  localparam int CNT_W       = 8;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   en;
  logic                   overwrite;
  logic [DATA_W-1:0]      pc_in;
  logic [DATA_W-1:0]      alu_in;
  logic                   bp_en;
  logic [DATA_W-1:0]      bp_addr;
  logic                   resume;
  logic                   rd_en;
  logic [DATA_W-1:0]      rd_pc;
  logic [DATA_W-1:0]      rd_alu;
  logic                   empty;
  logic                   full;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic [CNT_W-1:0]       cycle_cnt;
  logic [CNT_W-1:0]       instr_cnt;
  logic                   halted;
  logic                   bp_hit;
  logic [1:0]             state;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  cpu_trace_monitor #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .HALT_CYCLES(HALT_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .overwrite(overwrite), .pc_in(pc_in),
    .alu_in(alu_in), .bp_en(bp_en), .bp_addr(bp_addr), .resume(resume),
    .rd_en(rd_en), .rd_pc(rd_pc), .rd_alu(rd_alu), .empty(empty), .full(full),
    .count(count), .overflow(overflow), .cycle_cnt(cycle_cnt),
    .instr_cnt(instr_cnt), .halted(halted), .bp_hit(bp_hit), .state(state)
  );

  // Clock.
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 running, 2 halted, 3 frozen at breakpoint.
  int               m_mode = 0;
  int               m_same = 0;   // unchanged PC samples since last change
  int               m_cyc  = 0;
  int               m_ins  = 0;
  bit               m_bp   = 1'b0;
  bit               m_ovf  = 1'b0;
  logic [DATA_W-1:0] m_pc_q = '0;
  logic [2*DATA_W-1:0] exp_q[$];

  always @(posedge clk or negedge rst) begin : model
    bit           chg;
    bit           do_push;
    bit           do_pop;
    trace_entry_t e;
    if (!rst) begin
      m_mode = 0; m_same = 0; m_cyc = 0; m_ins = 0;
      m_bp = 1'b0; m_ovf = 1'b0; m_pc_q = '0;
      exp_q.delete();
    end else begin
      chg     = (pc_in != m_pc_q);
      do_push = 1'b0;
      do_pop  = rd_en && (exp_q.size() > 0);
      m_bp    = 1'b0;
      if (m_mode == 0) begin
        if (en) begin m_mode = 1; m_same = 0; end
      end else if (m_mode == 1) begin
        if (en) begin
          if (m_cyc < CNT_MAX) m_cyc++;
          if (chg) begin
            do_push = 1'b1;
            if (m_ins < CNT_MAX) m_ins++;
            m_same = 0;
            if (bp_en && pc_in == bp_addr) begin m_mode = 3; m_bp = 1'b1; end
          end else begin
            m_same++;
            if (m_same == HALT_CYCLES) begin m_mode = 2; m_same = 0; end
          end
        end
      end else if (m_mode == 2) begin
        if (en) begin
          if (m_cyc < CNT_MAX) m_cyc++;
          if (chg) begin
            do_push = 1'b1;
            if (m_ins < CNT_MAX) m_ins++;
            m_same = 0;
            m_mode = 1;
          end
        end
      end else begin
        m_same = 0;
        if (resume) m_mode = 1;
      end
      e.pc  = m_pc_q;
      e.alu = alu_in;
      if (do_push && exp_q.size() == DEPTH && !do_pop) begin
        m_ovf = 1'b1;
        if (overwrite) begin
          void'(exp_q.pop_front());
          exp_q.push_back(e);
        end
      end else begin
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(e);
      end
      m_pc_q = pc_in;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin : compare
    trace_entry_t h;
    if (chk_on) begin
      check("state",     64'(state),     64'(m_mode));
      check("halted",    64'(halted),    64'(m_mode == 2));
      check("bp_hit",    64'(bp_hit),    64'(m_bp));
      check("count",     64'(count),     64'(exp_q.size()));
      check("empty",     64'(empty),     64'(exp_q.size() == 0));
      check("full",      64'(full),      64'(exp_q.size() == DEPTH));
      check("overflow",  64'(overflow),  64'(m_ovf));
      check("cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
      check("instr_cnt", 64'(instr_cnt), 64'(m_ins));
      if (exp_q.size() > 0) h = exp_q[0];
      else h = '0;
      check("rd_pc",  64'(rd_pc),  64'(h.pc));
      check("rd_alu", 64'(rd_alu), 64'(h.alu));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; overwrite = 1'b0; pc_in = '0; alu_in = '0;
    bp_en = 1'b0; bp_addr = '0; resume = 1'b0; rd_en = 1'b0;
    cyc(2);
    rst = 1'b1;
  endtask

  task automatic set_pc(input logic [DATA_W-1:0] pc, input logic [DATA_W-1:0] alu);
    pc_in  = pc;
    alu_in = alu;
  endtask

  int hold;

  initial begin
    do_reset();
    chk_on = 1'b1;
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_state", 64'(state), 64'd0);
    check("rst_cycle", 64'(cycle_cnt), 64'd0);

    // Retire sequence 0,4,8,12, one PC per 4 cycles.
    en = 1'b1;
    set_pc(32'h0, 32'h11); cyc(4);
    set_pc(32'h4, 32'h22); cyc(4);
    set_pc(32'h8, 32'h33); cyc(4);
    set_pc(32'hC, 32'h44); cyc(4);
    check("seq_instr", 64'(instr_cnt), 64'd3);
    check("seq_count", 64'(count), 64'd3);
    check("seq_cycle", 64'(cycle_cnt), 64'd15);
    check("seq_h0_pc", 64'(rd_pc), 64'h0);
    check("seq_h0_alu", 64'(rd_alu), 64'h22);
    rd_en = 1'b1;
    cyc(1);
    check("seq_h1_pc", 64'(rd_pc), 64'h4);
    check("seq_h1_alu", 64'(rd_alu), 64'h33);
    cyc(1);
    check("seq_h2_pc", 64'(rd_pc), 64'h8);
    check("seq_h2_alu", 64'(rd_alu), 64'h44);
    cyc(1);
    check("seq_drained", 64'(empty), 64'd1);
    rd_en = 1'b0;

    // Halt after HALT_CYCLES unchanged samples, then resume on a PC change.
    set_pc(32'h20, 32'h55); cyc(8);
    check("halt_early", 64'(halted), 64'd0);
    cyc(1);
    check("halt_flag", 64'(halted), 64'd1);
    check("halt_state", 64'(state), 64'd2);
    set_pc(32'h24, 32'h66); cyc(1);
    check("unhalt_state", 64'(state), 64'd1);
    check("unhalt_count", 64'(count), 64'd2);
    check("unhalt_instr", 64'(instr_cnt), 64'd5);
    rd_en = 1'b1;
    cyc(1);
    check("unhalt_pc", 64'(rd_pc), 64'h20);
    check("unhalt_alu", 64'(rd_alu), 64'h66);
    cyc(1);
    rd_en = 1'b0;

    // Six retires into a 4-deep FIFO, dropping the new entries.
    do_reset();
    en = 1'b1;
    set_pc(32'h100, 32'hA0); cyc(1);
    for (int i = 1; i <= 6; i++) begin
      set_pc(32'h100 + 32'(4 * i), 32'hA0 + 32'(i)); cyc(1);
    end
    check("drop_count", 64'(count), 64'd4);
    check("drop_ovf", 64'(overflow), 64'd1);
    check("drop_head_pc", 64'(rd_pc), 64'h100);
    check("drop_head_alu", 64'(rd_alu), 64'hA1);

    // Same with overwrite: the last four survive.
    do_reset();
    en = 1'b1; overwrite = 1'b1;
    set_pc(32'h100, 32'hA0); cyc(1);
    for (int i = 1; i <= 6; i++) begin
      set_pc(32'h100 + 32'(4 * i), 32'hA0 + 32'(i)); cyc(1);
    end
    check("ovw_count", 64'(count), 64'd4);
    check("ovw_ovf", 64'(overflow), 64'd1);
    check("ovw_head_pc", 64'(rd_pc), 64'h108);
    check("ovw_head_alu", 64'(rd_alu), 64'hA3);

    // Full FIFO with a simultaneous pop and retire: no loss.
    do_reset();
    en = 1'b1;
    set_pc(32'h200, 32'hB0); cyc(1);
    for (int i = 1; i <= 4; i++) begin
      set_pc(32'h200 + 32'(4 * i), 32'hB0 + 32'(i)); cyc(1);
    end
    check("sim_full", 64'(full), 64'd1);
    rd_en = 1'b1;
    set_pc(32'h214, 32'hB5); cyc(1);
    rd_en = 1'b0;
    check("sim_count", 64'(count), 64'd4);
    check("sim_ovf", 64'(overflow), 64'd0);
    check("sim_head_pc", 64'(rd_pc), 64'h204);

    // Breakpoint at 0x8.
    do_reset();
    en = 1'b1; bp_en = 1'b1; bp_addr = 32'h8;
    set_pc(32'h0, 32'h1); cyc(1);
    set_pc(32'h4, 32'h2); cyc(1);
    set_pc(32'h8, 32'h3); cyc(1);
    check("bp_pulse", 64'(bp_hit), 64'd1);
    check("bp_state", 64'(state), 64'd3);
    set_pc(32'hC, 32'h4); cyc(1);
    check("bp_pulse_end", 64'(bp_hit), 64'd0);
    check("bp_frozen_count", 64'(count), 64'd2);
    cyc(1);
    resume = 1'b1; cyc(1); resume = 1'b0;
    check("bp_resumed", 64'(state), 64'd1);
    check("bp_no_log", 64'(count), 64'd2);
    set_pc(32'h10, 32'h77); cyc(1);
    check("bp_after_count", 64'(count), 64'd3);
    rd_en = 1'b1; cyc(2); rd_en = 1'b0;
    check("bp_c_pc", 64'(rd_pc), 64'hC);
    check("bp_c_alu", 64'(rd_alu), 64'h77);

    // Asynchronous reset with three entries held.
    do_reset();
    en = 1'b1;
    set_pc(32'h0, 32'h1); cyc(1);
    set_pc(32'h4, 32'h2); cyc(1);
    set_pc(32'h8, 32'h3); cyc(1);
    set_pc(32'hC, 32'h4); cyc(1);
    check("ar_pre_count", 64'(count), 64'd3);
    #2 rst = 1'b0;
    #1;
    check("ar_empty", 64'(empty), 64'd1);
    check("ar_count", 64'(count), 64'd0);
    check("ar_cycle", 64'(cycle_cnt), 64'd0);
    check("ar_instr", 64'(instr_cnt), 64'd0);
    check("ar_state", 64'(state), 64'd0);
    cyc(1);
    rst = 1'b1;

    // Randomized run; counters saturate along the way.
    do_reset();
    bp_addr = 32'h10;
    hold = 0;
    for (int c = 0; c < 900; c++) begin
      if (c == 450) begin
        do_reset();
        bp_addr = 32'h10;
      end
      en = ($urandom_range(0, 9) != 0);
      if (hold > 0) hold--;
      else begin
        if ($urandom_range(0, 3) == 0) hold = int'($urandom_range(8, 14));
        pc_in = $urandom_range(0, 7) << 2;
      end
      alu_in = $urandom();
      bp_en  = 1'($urandom_range(0, 1));
      resume = ($urandom_range(0, 5) == 0);
      rd_en  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 31) == 0) overwrite = ~overwrite;
      cyc(1);
    end

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
